// File: rtl/sprite_palette_bank.sv
// Multi-bank sprite palette: registered colour lookup with transparency and a frame-timed hit flash.
// Optional macro PALETTE_WRITE_EN enables the runtime palette write port; otherwise the palette is a constant gray ramp.
module sprite_palette_bank #(
    parameter int INDEX_W         = 4,
    parameter int COLOR_W         = 4,
    parameter int NUM_BANKS       = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FLASH_TICKS     = 6,
    localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic                   pix_valid,
    input  logic [BANK_W-1:0]      bank_sel,
    input  logic [INDEX_W-1:0]     index,
    input  logic                   wr_en,
    input  logic [BANK_W-1:0]      wr_bank,
    input  logic [INDEX_W-1:0]     wr_index,
    input  logic [3*COLOR_W-1:0]   wr_rgb,
    input  logic                   flash_start,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   out_valid,
    output logic                   out_transparent,
    output logic                   flash_busy
);
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TICK_W  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FLASH_TICKS - 1);

    typedef enum logic {IDLE, FLASH} state_t;

    function automatic logic bank_ok(input logic [BANK_W-1:0] b);
        return int'(b) < NUM_BANKS;
    endfunction

    function automatic logic [RGB_W-1:0] gray(input int i);
        logic [COLOR_W-1:0] c;
        c = i[COLOR_W-1:0];
        return {c, c, c};
    endfunction

    logic [RGB_W-1:0] rd_rgb;

`ifdef PALETTE_WRITE_EN
    logic [RGB_W-1:0] palette [NUM_BANKS][ENTRIES];

    // NOTE: storage is register-based, so the gray ramp is loaded by reset rather than by an init file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int e = 0; e < ENTRIES; e++)
                    palette[b][e] <= gray(e);
        end else if (wr_en && bank_ok(wr_bank)) begin
            palette[wr_bank][wr_index] <= wr_rgb;
        end
    end

    always_comb begin
        rd_rgb = '0;
        if (bank_ok(bank_sel))
            rd_rgb = palette[bank_sel][index];
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_bank, wr_index, wr_rgb};

    // Every bank holds the same constant ramp, so the lookup reduces to the index itself.
    always_comb begin
        rd_rgb = gray(int'(index));
    end
`endif

    state_t            state, next_state;
    logic [TICK_W-1:0] tick_cnt, next_cnt;
    logic              phase, next_phase;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            phase    <= 1'b0;
        end else begin
            state    <= next_state;
            tick_cnt <= next_cnt;
            phase    <= next_phase;
        end
    end

    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        next_state = state;
        next_cnt   = tick_cnt;
        next_phase = phase;
        unique case (state)
            IDLE: begin
                if (flash_start) begin
                    next_state = FLASH;
                    next_cnt   = '0;
                    next_phase = 1'b1;
                end
            end
            FLASH: begin
                if (flash_start) begin
                    next_cnt   = '0;
                    next_phase = 1'b1;
                end else if (frame_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                        next_phase = 1'b0;
                    end else begin
                        next_cnt   = tick_cnt + 1'b1;
                        next_phase = ~phase;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign flash_busy = (state == FLASH);

    logic lookup_transparent;
    assign lookup_transparent = !bank_ok(bank_sel) || (index == INDEX_W'(TRANSPARENT_IDX));

    // Colour and transparency only update on a valid request; otherwise they hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {red, green, blue} <= '0;
            out_valid          <= 1'b0;
            out_transparent    <= 1'b0;
        end else begin
            out_valid <= pix_valid;
            if (pix_valid) begin
                if (lookup_transparent) begin
                    {red, green, blue} <= '0;
                    out_transparent    <= 1'b1;
                end else begin
                    {red, green, blue} <= phase ? '1 : rd_rgb;
                    out_transparent    <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: lookup vector table plus write, flash and reset sequences.
module tb_sprite_palette_bank;
    logic        clk;
    logic        reset_n;
    logic        frame_tick;
    logic        pix_valid;
    logic [1:0]  bank_sel;
    logic [3:0]  index;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [3:0]  wr_index;
    logic [11:0] wr_rgb;
    logic        flash_start;
    logic [3:0]  red, green, blue;
    logic        out_valid;
    logic        out_transparent;
    logic        flash_busy;

    int total = 0;
    int bad   = 0;

    sprite_palette_bank dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_tick      (frame_tick),
        .pix_valid       (pix_valid),
        .bank_sel        (bank_sel),
        .index           (index),
        .wr_en           (wr_en),
        .wr_bank         (wr_bank),
        .wr_index        (wr_index),
        .wr_rgb          (wr_rgb),
        .flash_start     (flash_start),
        .red             (red),
        .green           (green),
        .blue            (blue),
        .out_valid       (out_valid),
        .out_transparent (out_transparent),
        .flash_busy      (flash_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [1:0]  bank;
        logic [3:0]  idx;
        logic        exp_valid;
        logic [11:0] exp_rgb;
        logic        exp_trans;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [1:0] b, input logic [3:0] i);
        pix_valid = 1'b1;
        bank_sel  = b;
        index     = i;
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic write(input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
        wr_en    = 1'b1;
        wr_bank  = b;
        wr_index = i;
        wr_rgb   = rgb;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    logic [11:0] exp_a42, exp_123;

    initial begin
`ifdef PALETTE_WRITE_EN
        exp_a42 = 12'hA42;
        exp_123 = 12'h123;
`else
        exp_a42 = 12'h333;
        exp_123 = 12'h999;
`endif
        vecs[0] = '{1'b1, 2'd2, 4'd5,  1'b1, 12'h555, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 4'd15, 1'b1, 12'hFFF, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 4'd0,  1'b1, 12'h000, 1'b1};
        vecs[3] = '{1'b0, 2'd1, 4'd9,  1'b0, 12'h000, 1'b1};
        vecs[4] = '{1'b1, 2'd1, 4'd9,  1'b1, 12'h999, 1'b0};
        vecs[5] = '{1'b0, 2'd2, 4'd3,  1'b0, 12'h999, 1'b0};
        vecs[6] = '{1'b1, 2'd3, 4'd1,  1'b1, 12'h111, 1'b0};

        reset_n = 1'b0; frame_tick = 1'b0; pix_valid = 1'b0; bank_sel = '0; index = '0;
        wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0; flash_start = 1'b0;
        #13;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_rgb", 32'({red, green, blue}), 32'h0);
        check("reset_trans", 32'(out_transparent), 32'd0);
        check("reset_busy", 32'(flash_busy), 32'd0);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            pix_valid = vecs[v].pv;
            bank_sel  = vecs[v].bank;
            index     = vecs[v].idx;
            tick();
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_rgb", v), 32'({red, green, blue}), 32'(vecs[v].exp_rgb));
            check($sformatf("vec%0d_trans", v), 32'(out_transparent), 32'(vecs[v].exp_trans));
        end
        pix_valid = 1'b0;

        // Same-cycle write and lookup of one entry returns the old value.
        pix_valid = 1'b1; bank_sel = 2'd1; index = 4'd3;
        write(2'd1, 4'd3, 12'hA42);
        check("rbw_old", 32'({red, green, blue}), 32'h333);
        lookup(2'd1, 4'd3);
        check("rbw_new", 32'({red, green, blue}), 32'(exp_a42));
        lookup(2'd0, 4'd3);
        check("other_bank", 32'({red, green, blue}), 32'h333);
        write(2'd0, 4'd9, 12'h123);
        lookup(2'd0, 4'd9);
        check("write_b0_i9", 32'({red, green, blue}), 32'(exp_123));
        write(2'd2, 4'd0, 12'hF00);
        lookup(2'd2, 4'd0);
        check("trans_after_write_rgb", 32'({red, green, blue}), 32'h000);
        check("trans_after_write_flag", 32'(out_transparent), 32'd1);

        // Full flash sequence: colour alternates per frame starting at full white.
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        check("flash_busy_start", 32'(flash_busy), 32'd1);
        for (int k = 0; k < 6; k++) begin
            lookup(2'd0, 4'd7);
            check($sformatf("flash%0d_rgb", k), 32'({red, green, blue}),
                  (k % 2 == 0) ? 32'hFFF : 32'h777);
            lookup(2'd0, 4'd0);
            check($sformatf("flash%0d_trans", k), 32'(out_transparent), 32'd1);
            check($sformatf("flash%0d_trans_rgb", k), 32'({red, green, blue}), 32'h000);
            frame();
            check($sformatf("flash%0d_busy", k), 32'(flash_busy), (k < 5) ? 32'd1 : 32'd0);
        end
        lookup(2'd0, 4'd7);
        check("after_flash_rgb", 32'({red, green, blue}), 32'h777);

        // Restart after the third tick; restart wins over a same-cycle frame_tick.
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        for (int k = 0; k < 3; k++) frame();
        flash_start = 1'b1;
        frame();
        flash_start = 1'b0;
        lookup(2'd0, 4'd7);
        check("restart_phase", 32'({red, green, blue}), 32'hFFF);
        for (int k = 0; k < 6; k++) begin
            frame();
            check($sformatf("restart%0d_busy", k), 32'(flash_busy), (k < 5) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of a flash and a lookup.
        flash_start = 1'b1;
        tick();
        flash_start = 1'b0;
        pix_valid = 1'b1; bank_sel = 2'd0; index = 4'd7;
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", 32'(flash_busy), 32'd0);
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_rgb", 32'({red, green, blue}), 32'h0);
        #2 reset_n = 1'b1;
        pix_valid = 1'b0;
        tick();
        lookup(2'd1, 4'd3);
        check("reset_palette", 32'({red, green, blue}), 32'h333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
# sprite_palette_bank

Parametrised multi-bank sprite palette with runtime-writable entries, registered lookup, transparent-index detection and a frame-timed hit-flash effect. Sits between the sprite ROM index outputs and the VGA colour mux: each pixel's colour index plus bank select becomes a 3-channel colour one cycle later. Separate banks let each tank or sprite class use its own colour scheme and be recoloured at runtime without touching sprite ROMs.

## Interface
- INDEX_W, 4, colour index width; entries per bank = 2^INDEX_W
- COLOR_W, 4, bits per colour channel
- NUM_BANKS, 4, number of palettes; BANK_W = clog2(NUM_BANKS), min 1
- TRANSPARENT_IDX, 0, index reported as transparent
- FLASH_TICKS, 6, frame_tick count for one flash sequence

- Clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- pix_valid  in  1  lookup request this cycle
- bank_sel  in  BANK_W  bank for lookup
- index  in  INDEX_W  colour index for lookup
- wr_en  in  1  palette entry write strobe
- wr_bank  in  BANK_W  bank to write
- wr_index  in  INDEX_W  entry to write
- wr_rgb  in  3*COLOR_W  {red, green, blue}
- flash_start  in  1  start/restart hit flash
- red, green, blue  out  COLOR_W each  looked-up colour
- out_valid  out  1  colour outputs valid
- out_transparent  out  1  looked-up index was TRANSPARENT_IDX
- flash_busy  out  1  flash sequence active

## Operation
- Storage: NUM_BANKS x 2^INDEX_W entries of 3*COLOR_W bits in registers.
- Reset contents: every bank, entry i = gray with each channel = i mod 2^COLOR_W (defaults: entry 0 = 000, entry 15 = FFF).
- Lookup: pix_valid registered to out_valid; colour = entry[bank_sel][index] registered. bank_sel >= NUM_BANKS returns 0 colour, out_transparent=1.
- Transparency: index == TRANSPARENT_IDX -> out_transparent=1, colour outputs 0, regardless of stored entry or flash.
- Write: wr_en writes wr_rgb into [wr_bank][wr_index] at clock edge; wr_bank >= NUM_BANKS ignored.
- Same-cycle write and lookup of same entry: lookup returns old value (read-before-write); new value visible to lookups issued next cycle onward.
- Flash FSM, states IDLE, FLASH:
  - IDLE: flash_start -> FLASH, tick_cnt=0, phase=1.
  - FLASH: each frame_tick increments tick_cnt and inverts phase; when tick_cnt reaches FLASH_TICKS-1 and frame_tick arrives -> IDLE, phase=0.
  - flash_start in FLASH restarts: tick_cnt=0, phase=1 (priority over frame_tick same cycle).
  - flash_busy = (state == FLASH).
- While phase=1, non-transparent lookups output all channels = 2^COLOR_W-1; phase sampled in the same cycle as pix_valid.
- When pix_valid=0, colour outputs hold previous values; out_transparent holds.

## Timing
- Lookup latency 1 cycle: request at edge N, outputs valid after edge N+1; full throughput, one lookup per cycle.
- Write latency 1 cycle; no back-pressure, no stall.
- Reset values: red/green/blue=0, out_valid=0, out_transparent=0, flash_busy=0, state IDLE, tick_cnt=0, phase=0, palette = gray ramp.
- Reset asserted mid-flash or mid-lookup: all of the above immediately (asynchronously); out_valid drops same instant.
- tick_cnt width clog2(FLASH_TICKS), min 1; no wrap beyond FLASH_TICKS-1.

## Configuration
- PALETTE_WRITE_EN defined: runtime write port active as above.
- Not defined: wr_en, wr_bank, wr_index, wr_rgb ignored; palette is constant reset contents (synthesises to ROM/LUT logic, no storage flops); lookup, transparency and flash unchanged.

## Test plan
- Reset, then lookup bank 2 index 5 -> one cycle later out_valid=1, rgb=5/5/5, out_transparent=0.
- Write bank 1 index 3 = {A,4,2}, lookup same entry in same cycle -> 3/3/3; lookup next cycle -> A/4/2; bank 0 index 3 still 3/3/3.
- Lookup index 0 after writing entry 0 = {F,0,0} -> out_transparent=1, rgb=0/0/0.
- flash_start, then 6 frame_ticks with continuous lookups of index 7 -> output alternates F/F/F, 7/7/7 per frame starting F/F/F; flash_busy falls on 6th tick; index 0 stays transparent throughout.
- flash_start after 3rd tick -> count restarts, flash_busy held 6 more ticks; reset_n low mid-flash -> flash_busy=0, out_valid=0 immediately, palette back to gray ramp.
- Build without PALETTE_WRITE_EN: write bank 0 index 9 = {1,2,3}, lookup -> 9/9/9.
